traffic_light_monitor: RTL and testbench
========================================

# traffic_light_monitor

- Independent conflict monitor on the two light buses (`ns_light`, `ew_light`) driven by the traffic light controller.
- Decodes the light patterns into phases and checks phase order and per-phase dwell time.
- On any violation, latches a sticky fault with a code and forces its registered safe light outputs to all-red.
- Sits between the controller and the lamp drivers; the lamp drivers consume `safe_ns`/`safe_ew`.

## Interface

Parameters:
- CNT_W, 8: width of the dwell counter.
- MIN_GREEN, 4: minimum legal green dwell, in cycles.
- MAX_GREEN, 16: maximum legal green dwell, in cycles.
- MIN_YELLOW, 2: minimum legal yellow dwell, in cycles.
- MAX_YELLOW, 4: maximum legal yellow dwell, in cycles.
- All MIN/MAX values are ≥1, MIN ≤ MAX, and each MAX < 2^CNT_W.

Ports (clock is clk; reset is reset, asynchronous, active-high):
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- ns_light  in  3  NS lamp pattern [Red,Yellow,Green]
- ew_light  in  3  EW lamp pattern [Red,Yellow,Green]
- fault_clr  in  1  synchronous clear of a latched fault
- safe_ns  out  3  registered NS lamp drive
- safe_ew  out  3  registered EW lamp drive
- phase  out  2  current phase: 0 NSG, 1 NSY, 2 EWG, 3 EWY
- phase_valid  out  1  high when in a tracking state
- dwell  out  CNT_W  cycles spent in the current phase (saturating)
- fault  out  1  sticky fault flag
- fault_code  out  3  code of the first fault; 0 means none
- cycle_count  out  16  number of completed NSG→NSY→EWG→EWY rounds (wraps)

## Operation

- Legal patterns:
  - NSG = ns 001 / ew 100
  - NSY = ns 010 / ew 100
  - EWG = ns 100 / ew 001
  - EWY = ns 100 / ew 010
- Checks are evaluated every edge on the sampled inputs, in priority order:
  1. ENC (code 1): either bus is not one-hot.
  2. CONFLICT (code 2): both buses one-hot but neither is red.
  3. SEQ (code 3): the pattern changes to anything other than the legal successor (NSG→NSY→EWG→EWY→NSG).
  4. SHORT (code 4): legal change while `dwell` < MIN of the departing phase.
  5. LONG (code 5): same pattern sampled while `dwell` == MAX of the current phase.
- States:
  - SYNC: entered after reset and after `fault_clr`. Only ENC and CONFLICT are checked. Exits to NSG on an EWY→NSG transition, with `dwell`=1.
  - NSG, NSY, EWG, EWY: all checks active. On a legal change, move to the successor state with `dwell`=1; otherwise `dwell`+1, saturating at 2^CNT_W−1.
  - FAULT: entered on any violation. `fault`=1 and `fault_code` hold the first code only. Leaves only via `fault_clr`, which goes to SYNC.
- `phase_valid`=1 only in NSG/NSY/EWG/EWY. In SYNC and FAULT, `phase` holds its last value.
- `cycle_count` increments on each EWY→NSG change taken while in the EWY state. It does not increment on the SYNC exit.
- `safe_ns`/`safe_ew`:
  - Registered copy of the inputs while in SYNC or a tracking state and no violation is detected at that edge.
  - Otherwise both are 100.
  - In FAULT both are 100.

## Timing

- Reset values: `safe_ns`=100, `safe_ew`=100, `phase`=0, `phase_valid`=0, `dwell`=0, `fault`=0, `fault_code`=0, `cycle_count`=0; state SYNC.
- Latency: a violating input present before edge N gives `fault`=1, `fault_code` valid, and safe outputs=100 immediately after edge N (1 cycle).
- Normal pass-through latency is 1 cycle.
- Simultaneous events:
  - `fault_clr` together with a violating sample: the clear wins, the state goes to SYNC, and that sample is ignored.
  - Several violations on the same edge: the lowest code is reported.
- Reset mid-fault clears everything asynchronously.
- `dwell` saturation never wraps. LONG triggers before saturation because MAX < 2^CNT_W.

## Structure

- Package `traffic_light_pkg` holds:
  - Light constants: RED=100, YELLOW=010, GREEN=001.
  - Phase encodings 0–3.
  - Fault codes 0–5.
  - Monitor state encoding.
- Sub-module `tl_dwell_counter` (CNT_W): saturating counter with synchronous load-1 and increment, plus async reset to 0.

## Test plan

- **Clean rounds:** drive a legal sequence with green=6 and yellow=3, starting at EWY. Required: the SYNC exit at NSG, `phase_valid`=1, `cycle_count`=3 after three full rounds, `fault`=0, and safe outputs equal to the inputs delayed 1 cycle.
- **Conflict:** while in EWG, drive ns=001 / ew=001 for one cycle. Required: next cycle `fault`=1, `fault_code`=2, safe outputs 100/100, held until `fault_clr`.
- **Encoding error:** drive ns=011 while in SYNC. Required: `fault_code`=1. A following CONFLICT pattern leaves the code at 1.
- **Short and long dwell:**
  - NSY after only 3 NSG cycles: `fault_code`=4.
  - After clear and resync, hold NSG for 17 cycles: `fault_code`=5 at the edge where `dwell` reaches 16 and NSG is sampled again.
- **Sequence:** while tracking, go NSG→EWG directly. Required: `fault_code`=3.
- **Clear and reset:**
  - `fault_clr` together with a conflict: `fault`=0 and state SYNC.
  - Async reset asserted mid-round: all outputs return to their reset values without waiting for a clock edge.

Source files
------------

// File: rtl/traffic_light_pkg.sv
// Shared lamp patterns, phase/fault encodings and monitor states for the
// traffic light conflict monitor.
package traffic_light_pkg;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;

    typedef enum logic [1:0] {
        PH_NSG = 2'd0,
        PH_NSY = 2'd1,
        PH_EWG = 2'd2,
        PH_EWY = 2'd3
    } phase_e;

    typedef enum logic [2:0] {
        FC_NONE     = 3'd0,
        FC_ENC      = 3'd1,
        FC_CONFLICT = 3'd2,
        FC_SEQ      = 3'd3,
        FC_SHORT    = 3'd4,
        FC_LONG     = 3'd5
    } fault_code_e;

    typedef enum logic [2:0] {
        ST_SYNC  = 3'd0,
        ST_NSG   = 3'd1,
        ST_NSY   = 3'd2,
        ST_EWG   = 3'd3,
        ST_EWY   = 3'd4,
        ST_FAULT = 3'd5
    } mon_state_e;

    function automatic logic is_onehot3(input logic [2:0] v);
        return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
    endfunction

    function automatic logic [2:0] phase_ns(input phase_e p);
        case (p)
            PH_NSG:  return GREEN;
            PH_NSY:  return YELLOW;
            default: return RED;
        endcase
    endfunction

    function automatic logic [2:0] phase_ew(input phase_e p);
        case (p)
            PH_EWG:  return GREEN;
            PH_EWY:  return YELLOW;
            default: return RED;
        endcase
    endfunction

    function automatic mon_state_e phase_state(input phase_e p);
        case (p)
            PH_NSG:  return ST_NSG;
            PH_NSY:  return ST_NSY;
            PH_EWG:  return ST_EWG;
            default: return ST_EWY;
        endcase
    endfunction

    function automatic logic is_tracking(input mon_state_e s);
        return (s == ST_NSG) || (s == ST_NSY) || (s == ST_EWG) || (s == ST_EWY);
    endfunction

endpackage

// File: rtl/traffic_light_monitor_dwell_counter.sv
// Saturating dwell counter: load-1 on phase entry, increment while the phase holds.
module tl_dwell_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_one,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_one) begin
            cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/traffic_light_monitor.sv
// Independent conflict monitor: tracks NS/EW lamp phases, checks order and dwell,
// latches the first fault and forces all-red safe outputs.
module traffic_light_monitor
    import traffic_light_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int MIN_GREEN  = 4,
    parameter int MAX_GREEN  = 16,
    parameter int MIN_YELLOW = 2,
    parameter int MAX_YELLOW = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       ns_light,
    input  logic [2:0]       ew_light,
    input  logic             fault_clr,
    output logic [2:0]       safe_ns,
    output logic [2:0]       safe_ew,
    output logic [1:0]       phase,
    output logic             phase_valid,
    output logic [CNT_W-1:0] dwell,
    output logic             fault,
    output logic [2:0]       fault_code,
    output logic [15:0]      cycle_count
);

    mon_state_e       state_q, state_d;
    phase_e           phase_q, phase_d, trk_phase_s, succ_phase_s;
    fault_code_e      fault_code_q, fault_code_d, viol_code_s;
    logic [2:0]       last_ns_q, last_ns_d, last_ew_q, last_ew_d;
    logic [2:0]       safe_ns_q, safe_ns_d, safe_ew_q, safe_ew_d;
    logic             phase_valid_q, phase_valid_d;
    logic             fault_q, fault_d;
    logic [15:0]      cycle_count_q, cycle_count_d;
    logic [CNT_W-1:0] dwell_s, min_s, max_s;
    logic             tracking_s, same_s, succ_s, legal_move_s;
    logic             viol_s, sync_exit_s, dwell_load_s, dwell_inc_s;

    always_comb begin
        case (state_q)
            ST_NSY:  trk_phase_s = PH_NSY;
            ST_EWG:  trk_phase_s = PH_EWG;
            ST_EWY:  trk_phase_s = PH_EWY;
            default: trk_phase_s = PH_NSG;
        endcase
    end

    // Violation checks in priority order; lower codes shadow higher ones.
    always_comb begin
        tracking_s   = is_tracking(state_q);
        succ_phase_s = phase_e'(trk_phase_s + 2'd1);
        same_s       = (ns_light == phase_ns(trk_phase_s)) && (ew_light == phase_ew(trk_phase_s));
        succ_s       = (ns_light == phase_ns(succ_phase_s)) && (ew_light == phase_ew(succ_phase_s));
        if ((trk_phase_s == PH_NSG) || (trk_phase_s == PH_EWG)) begin
            min_s = CNT_W'(MIN_GREEN);
            max_s = CNT_W'(MAX_GREEN);
        end else begin
            min_s = CNT_W'(MIN_YELLOW);
            max_s = CNT_W'(MAX_YELLOW);
        end
        legal_move_s = 1'b0;
        viol_code_s  = FC_NONE;
        if (!is_onehot3(ns_light) || !is_onehot3(ew_light)) begin
            viol_code_s = FC_ENC;
        end else if ((ns_light != RED) && (ew_light != RED)) begin
            viol_code_s = FC_CONFLICT;
        end else if (tracking_s) begin
            if (same_s) begin
                viol_code_s = (dwell_s == max_s) ? FC_LONG : FC_NONE;
            end else if (succ_s) begin
                if (dwell_s < min_s) begin
                    viol_code_s = FC_SHORT;
                end else begin
                    legal_move_s = 1'b1;
                end
            end else begin
                viol_code_s = FC_SEQ;
            end
        end else begin
            viol_code_s = FC_NONE;
        end
        viol_s      = (state_q != ST_FAULT) && (viol_code_s != FC_NONE);
        sync_exit_s = (state_q == ST_SYNC) && !viol_s
                    && (last_ns_q == RED) && (last_ew_q == YELLOW)
                    && (ns_light == GREEN) && (ew_light == RED);
    end

    always_comb begin
        state_d = state_q;
        if (fault_clr) begin
            state_d = ST_SYNC;
        end else begin
            case (state_q)
                ST_SYNC: begin
                    if (viol_s) begin
                        state_d = ST_FAULT;
                    end else if (sync_exit_s) begin
                        state_d = ST_NSG;
                    end else begin
                        state_d = ST_SYNC;
                    end
                end
                ST_NSG, ST_NSY, ST_EWG, ST_EWY: begin
                    if (viol_s) begin
                        state_d = ST_FAULT;
                    end else if (legal_move_s) begin
                        state_d = phase_state(succ_phase_s);
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_FAULT: state_d = ST_FAULT;
                default:  state_d = ST_FAULT;
            endcase
        end
    end

    // Output next-values; a clear always wins and its sample is ignored.
    always_comb begin
        safe_ns_d     = RED;
        safe_ew_d     = RED;
        fault_d       = fault_q;
        fault_code_d  = fault_code_q;
        phase_d       = phase_q;
        cycle_count_d = cycle_count_q;
        dwell_load_s  = 1'b0;
        dwell_inc_s   = 1'b0;
        if (fault_clr) begin
            fault_d      = 1'b0;
            fault_code_d = FC_NONE;
        end else if (state_q == ST_FAULT) begin
            fault_d = 1'b1;
        end else if (viol_s) begin
            fault_d      = 1'b1;
            fault_code_d = viol_code_s;
        end else begin
            safe_ns_d = ns_light;
            safe_ew_d = ew_light;
            if (sync_exit_s) begin
                phase_d      = PH_NSG;
                dwell_load_s = 1'b1;
            end else if (legal_move_s) begin
                phase_d      = succ_phase_s;
                dwell_load_s = 1'b1;
                if (trk_phase_s == PH_EWY) begin
                    cycle_count_d = cycle_count_q + 16'd1;
                end else begin
                    cycle_count_d = cycle_count_q;
                end
            end else if (tracking_s) begin
                dwell_inc_s = 1'b1;
            end else begin
                dwell_inc_s = 1'b0;
            end
        end
        phase_valid_d = is_tracking(state_d);
        last_ns_d     = fault_clr ? RED : ns_light;
        last_ew_d     = fault_clr ? RED : ew_light;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            safe_ns_q     <= RED;
            safe_ew_q     <= RED;
            phase_q       <= PH_NSG;
            phase_valid_q <= 1'b0;
            fault_q       <= 1'b0;
            fault_code_q  <= FC_NONE;
            cycle_count_q <= 16'd0;
            last_ns_q     <= RED;
            last_ew_q     <= RED;
        end else begin
            safe_ns_q     <= safe_ns_d;
            safe_ew_q     <= safe_ew_d;
            phase_q       <= phase_d;
            phase_valid_q <= phase_valid_d;
            fault_q       <= fault_d;
            fault_code_q  <= fault_code_d;
            cycle_count_q <= cycle_count_d;
            last_ns_q     <= last_ns_d;
            last_ew_q     <= last_ew_d;
        end
    end

    tl_dwell_counter #(.CNT_W(CNT_W)) u_dwell (
        .clk      (clk),
        .reset    (reset),
        .load_one (dwell_load_s),
        .inc      (dwell_inc_s),
        .cnt      (dwell_s)
    );

    assign safe_ns     = safe_ns_q;
    assign safe_ew     = safe_ew_q;
    assign phase       = phase_q;
    assign phase_valid = phase_valid_q;
    assign dwell       = dwell_s;
    assign fault       = fault_q;
    assign fault_code  = fault_code_q;
    assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: directed scenarios plus random phase walks,
// checked every cycle against a pattern-table model of the monitor rules.
module tb_traffic_light_monitor;

    localparam int CNT_W      = 8;
    localparam int MIN_GREEN  = 4;
    localparam int MAX_GREEN  = 16;
    localparam int MIN_YELLOW = 2;
    localparam int MAX_YELLOW = 4;
    localparam int DMAX       = (1 << CNT_W) - 1;
    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] G = 3'b001;

    logic             clk = 1'b0;
    logic             reset, fault_clr;
    logic [2:0]       ns_light, ew_light;
    logic [2:0]       safe_ns, safe_ew;
    logic [1:0]       phase;
    logic             phase_valid, fault;
    logic [CNT_W-1:0] dwell;
    logic [2:0]       fault_code;
    logic [15:0]      cycle_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Legal patterns indexed by phase, with their dwell limits.
    int pat_ns [4] = '{1, 2, 4, 4};
    int pat_ew [4] = '{4, 4, 1, 2};
    int min_d  [4] = '{MIN_GREEN, MIN_YELLOW, MIN_GREEN, MIN_YELLOW};
    int max_d  [4] = '{MAX_GREEN, MAX_YELLOW, MAX_GREEN, MAX_YELLOW};

    bit m_trk, m_flt;
    int m_code, m_phase, m_dwell, m_cycles, m_prev, m_sns, m_sew;

    traffic_light_monitor #(
        .CNT_W(CNT_W), .MIN_GREEN(MIN_GREEN), .MAX_GREEN(MAX_GREEN),
        .MIN_YELLOW(MIN_YELLOW), .MAX_YELLOW(MAX_YELLOW)
    ) dut (
        .clk(clk), .reset(reset), .ns_light(ns_light), .ew_light(ew_light),
        .fault_clr(fault_clr), .safe_ns(safe_ns), .safe_ew(safe_ew),
        .phase(phase), .phase_valid(phase_valid), .dwell(dwell),
        .fault(fault), .fault_code(fault_code), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pat_idx(input logic [2:0] ns, input logic [2:0] ew);
        for (int i = 0; i < 4; i++) begin
            if ((int'(ns) == pat_ns[i]) && (int'(ew) == pat_ew[i])) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_trk = 1'b0; m_flt = 1'b0; m_code = 0; m_phase = 0; m_dwell = 0;
        m_cycles = 0; m_prev = -1; m_sns = 4; m_sew = 4;
    endtask

    task automatic model_step();
        int idx, c;
        idx = pat_idx(ns_light, ew_light);
        c = 0;
        m_sns = 4; m_sew = 4;
        if (fault_clr) begin
            m_flt = 1'b0; m_code = 0; m_trk = 1'b0; m_prev = -1;
            return;
        end
        if (m_flt) return;
        if (!$onehot(ns_light) || !$onehot(ew_light)) c = 1;
        else if (ns_light != 3'b100 && ew_light != 3'b100) c = 2;
        else if (m_trk) begin
            if (idx == m_phase) c = (m_dwell == max_d[m_phase]) ? 5 : 0;
            else if (idx == (m_phase + 1) % 4) c = (m_dwell < min_d[m_phase]) ? 4 : 0;
            else c = 3;
        end
        if (c != 0) begin
            m_flt = 1'b1; m_code = c; m_trk = 1'b0;
        end else begin
            m_sns = ns_light; m_sew = ew_light;
            if (m_trk) begin
                if (idx == m_phase) m_dwell = (m_dwell < DMAX) ? m_dwell + 1 : DMAX;
                else begin
                    if (m_phase == 3) m_cycles = (m_cycles + 1) % 65536;
                    m_phase = idx; m_dwell = 1;
                end
            end else if (m_prev == 3 && idx == 0) begin
                m_trk = 1'b1; m_phase = 0; m_dwell = 1;
            end
        end
        m_prev = idx;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("safe_ns", safe_ns, m_sns);
            check("safe_ew", safe_ew, m_sew);
            check("phase", phase, m_phase);
            check("phase_valid", phase_valid, m_trk);
            if (m_trk) check("dwell", dwell, m_dwell);
            check("fault", fault, m_flt);
            check("fault_code", fault_code, m_code);
            check("cycle_count", cycle_count, m_cycles);
        end
    end

    task automatic drive(input logic [2:0] ns, input logic [2:0] ew, input int n);
        for (int i = 0; i < n; i++) begin
            ns_light = ns; ew_light = ew;
            @(negedge clk);
        end
    endtask

    task automatic run_phase(input int p, input int n);
        drive(3'(pat_ns[p]), 3'(pat_ew[p]), n);
    endtask

    task automatic clear();
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
    endtask

    task automatic full_round();
        run_phase(0, 6); run_phase(1, 3); run_phase(2, 6); run_phase(3, 3);
    endtask

    initial begin
        int rp, r, len;
        reset = 1'b1; fault_clr = 1'b0; ns_light = R; ew_light = R;
        repeat (2) @(negedge clk);
        check("rst_safe_ns", safe_ns, 4);
        check("rst_safe_ew", safe_ew, 4);
        check("rst_phase_valid", phase_valid, 0);
        check("rst_dwell", dwell, 0);
        check("rst_fault_code", fault_code, 0);
        reset = 1'b0;

        // Clean rounds starting at EWY
        run_phase(3, 3);
        run_phase(0, 1);
        check("sync_exit_valid", phase_valid, 1);
        check("sync_exit_phase", phase, 0);
        check("sync_exit_dwell", dwell, 1);
        check("sync_exit_safe_ns", safe_ns, 1);
        check("sync_exit_count", cycle_count, 0);
        run_phase(0, 5); run_phase(1, 3); run_phase(2, 6); run_phase(3, 3);
        full_round(); full_round();
        run_phase(0, 1);
        check("rounds_count", cycle_count, 3);
        check("rounds_fault", fault, 0);

        // Conflict while in EWG
        run_phase(0, 5); run_phase(1, 3); run_phase(2, 2);
        drive(G, G, 1);
        check("conflict_code", fault_code, 2);
        check("conflict_safe_ns", safe_ns, 4);
        check("conflict_safe_ew", safe_ew, 4);
        run_phase(2, 3);
        check("conflict_held", fault_code, 2);
        clear();
        check("clr_fault", fault, 0);

        // Encoding error then conflict: first code stays
        drive(3'b011, R, 1);
        check("enc_code", fault_code, 1);
        drive(G, G, 1);
        check("enc_code_kept", fault_code, 1);
        clear();

        // Short green
        run_phase(3, 2); run_phase(0, 3); run_phase(1, 1);
        check("short_code", fault_code, 4);
        clear();

        // Long green
        run_phase(3, 2); run_phase(0, 16);
        check("long_dwell16", dwell, 16);
        check("long_nofault", fault, 0);
        run_phase(0, 1);
        check("long_code", fault_code, 5);
        clear();

        // Sequence skip NSG->EWG
        run_phase(3, 2); run_phase(0, 5); run_phase(2, 1);
        check("seq_code", fault_code, 3);
        clear();

        // Clear together with a conflict
        run_phase(3, 2); run_phase(0, 5);
        fault_clr = 1'b1; ns_light = G; ew_light = G;
        @(negedge clk);
        fault_clr = 1'b0;
        check("clr_conf_fault", fault, 0);
        check("clr_conf_valid", phase_valid, 0);
        drive(R, R, 1);

        // Random phase walks with glitches and clears
        rp = 3;
        for (int s = 0; s < 150; s++) begin
            r = $urandom_range(0, 31);
            if (r == 0) begin
                drive(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1);
            end else if (r == 1) begin
                clear();
            end else begin
                len = (rp % 2 == 0) ? $urandom_range(3, 17) : $urandom_range(1, 5);
                run_phase(rp, len);
                rp = (rp + 1) % 4;
            end
            if (m_flt) clear();
        end

        // Async reset mid-round
        clear();
        run_phase(3, 2); full_round(); run_phase(0, 5); run_phase(1, 1);
        #2 reset = 1'b1;
        #1;
        check("areset_safe_ns", safe_ns, 4);
        check("areset_safe_ew", safe_ew, 4);
        check("areset_phase", phase, 0);
        check("areset_valid", phase_valid, 0);
        check("areset_dwell", dwell, 0);
        check("areset_fault", fault, 0);
        check("areset_count", cycle_count, 0);
        @(negedge clk);
        reset = 1'b0;
        drive(R, R, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
